// File: rtl/spi_frame_ctrl.sv
// Deframes an SPI-style bit stream (length byte + payload) into a byte FIFO; push-to-visible latency 1 cycle.
// The consumer stalls via out_ready; when the FIFO is full with no pop, payload bytes are dropped and overflow is set.
module spi_frame_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       ser_bit,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_done,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_DONE} state_t;

  state_t         state, state_nxt;
  logic [7:0]     shreg;
  logic [7:0]     shreg_nxt;
  logic [2:0]     bit_cnt;
  logic [7:0]     rem, rem_nxt;
  logic           capture, byte_done;
  logic           push, pop, full, push_ok, ovf_set;
  logic           done_nxt, err_nxt;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr, rd_ptr_p1;
  logic [AW:0]    count;

  assign capture   = !cs_n && (state != S_DONE);
  assign shreg_nxt = {shreg[6:0], ser_bit};
  assign byte_done = capture && (bit_cnt == 3'd7);

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    push      = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: if (!cs_n) state_nxt = S_LEN;
      S_LEN: begin
        if (cs_n) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end else if (byte_done) begin
          rem_nxt   = shreg_nxt;
          state_nxt = (shreg_nxt == 8'd0) ? S_DONE : S_DATA;
        end
      end
      S_DATA: begin
        if (cs_n) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end else if (byte_done) begin
          // L counts dropped bytes too, so the frame boundary never depends on FIFO space
          push    = 1'b1;
          rem_nxt = rem - 8'd1;
          if (rem == 8'd1) state_nxt = S_DONE;
        end
      end
      S_DONE: if (cs_n) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    done_nxt = (state_nxt == S_DONE) && (state != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      shreg      <= 8'd0;
      bit_cnt    <= 3'd0;
      rem        <= 8'd0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      rem        <= rem_nxt;
      frame_done <= done_nxt;
      frame_err  <= err_nxt;
      if (ovf_set) overflow <= 1'b1;
      if (cs_n) begin
        shreg   <= 8'd0;
        bit_cnt <= 3'd0;
      end else if (capture) begin
        shreg   <= shreg_nxt;
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign out_valid = (count != '0);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign pop       = out_valid && out_ready;
  assign push_ok   = push && (!full || pop);
  assign ovf_set   = push && full && !pop;
  assign rd_ptr_p1 = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem[wr_ptr] <= shreg_nxt;
  end

  // out_data is a registered copy of the head so it keeps its last value once the FIFO drains
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_data <= 8'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr_p1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
      if (pop) begin
        if (count >= (AW+1)'(2)) out_data <= mem[rd_ptr_p1];
        else if (push_ok)        out_data <= shreg_nxt;
      end else if (push_ok && (count == '0)) begin
        out_data <= shreg_nxt;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: stimulus pushes expected bytes into a queue, a negedge monitor pops and compares.
module tb_spi_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, cs_n, ser_bit, out_ready;
  logic [7:0] out_data;
  logic       out_valid, frame_done, frame_err, overflow, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int pop_cnt  = 0;
  logic [7:0] exp_q[$];

  spi_frame_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .ser_bit(ser_bit),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .frame_done(frame_done), .frame_err(frame_err), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens on the next rising edge whenever valid and ready are seen here.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got 0x%0h, expected no output", out_data);
        end else begin
          check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
        end
      end
      if (frame_done) done_cnt++;
      if (frame_err)  err_cnt++;
    end
  end

  task automatic send_bit(input logic b);
    cs_n = 1'b0;
    ser_bit = b;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic idle_cycles(input int n);
    cs_n = 1'b1;
    ser_bit = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, p0;
    logic [7:0] b6 [5];
    b6 = '{8'h5A, 8'h3C, 8'h96, 8'hE1, 8'h0F};

    rst_n = 1'b0; cs_n = 1'b1; ser_bit = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_data", {24'd0, out_data}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_flags", {29'd0, frame_done, frame_err, overflow}, 0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Scenario 1: length 2, payload CA 3F, consumer always ready
    out_ready = 1'b1;
    d0 = done_cnt;
    exp_q.push_back(8'hCA); exp_q.push_back(8'h3F);
    send_byte(8'h02);
    check("s1_busy", {31'd0, busy}, 1);
    send_byte(8'hCA);
    check("s1_valid_ca", {31'd0, out_valid}, 1);
    check("s1_data_ca", {24'd0, out_data}, 32'hCA);
    send_byte(8'h3F);
    check("s1_valid_3f", {31'd0, out_valid}, 1);
    check("s1_data_3f", {24'd0, out_data}, 32'h3F);
    check("s1_done", {31'd0, frame_done}, 1);
    idle_cycles(1);
    check("s1_done_width", {31'd0, frame_done}, 0);
    check("s1_busy_end", {31'd0, busy}, 0);
    idle_cycles(2);
    check("s1_done_count", done_cnt - d0, 1);
    check("s1_queue_empty", exp_q.size(), 0);

    // Scenario 2: zero length, trailing bits ignored
    d0 = done_cnt; p0 = pop_cnt;
    send_byte(8'h00);
    check("s2_done", {31'd0, frame_done}, 1);
    send_byte(8'hFF);
    check("s2_busy_done", {31'd0, busy}, 1);
    check("s2_no_valid", {31'd0, out_valid}, 0);
    idle_cycles(2);
    check("s2_busy_end", {31'd0, busy}, 0);
    check("s2_done_count", done_cnt - d0, 1);
    check("s2_no_pops", pop_cnt - p0, 0);

    // Scenario 3: abort mid-byte after one payload byte
    d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back(8'h11);
    send_byte(8'h03);
    send_byte(8'h11);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    idle_cycles(1);
    check("s3_err", {31'd0, frame_err}, 1);
    check("s3_busy", {31'd0, busy}, 0);
    idle_cycles(1);
    check("s3_err_width", {31'd0, frame_err}, 0);
    idle_cycles(2);
    check("s3_err_count", err_cnt - e0, 1);
    check("s3_no_done", done_cnt - d0, 0);
    check("s3_queue_empty", exp_q.size(), 0);

    // Scenario 6: fill FIFO, then push and pop on the same edge
    out_ready = 1'b0;
    p0 = pop_cnt;
    for (int i = 0; i < 5; i++) exp_q.push_back(b6[i]);
    send_byte(8'h05);
    for (int i = 0; i < 4; i++) send_byte(b6[i]);
    check("s6_full_valid", {31'd0, out_valid}, 1);
    for (int i = 7; i >= 1; i--) send_bit(b6[4][i]);
    out_ready = 1'b1;
    send_bit(b6[4][0]);
    out_ready = 1'b0;
    check("s6_no_overflow", {31'd0, overflow}, 0);
    check("s6_done", {31'd0, frame_done}, 1);
    check("s6_head", {24'd0, out_data}, 32'h3C);
    cs_n = 1'b1; out_ready = 1'b1;
    idle_cycles(8);
    check("s6_pop_count", pop_cnt - p0, 5);
    check("s6_queue_empty", exp_q.size(), 0);
    check("s6_drained", {31'd0, out_valid}, 0);

    // Scenario 4: stalled consumer, fifth byte overflows
    out_ready = 1'b0;
    p0 = pop_cnt;
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'hA0 + 8'(i));
    send_byte(8'h05);
    for (int i = 1; i <= 5; i++) send_byte(8'hA0 + 8'(i));
    check("s4_overflow", {31'd0, overflow}, 1);
    check("s4_done", {31'd0, frame_done}, 1);
    cs_n = 1'b1; out_ready = 1'b1;
    idle_cycles(8);
    check("s4_pop_count", pop_cnt - p0, 4);
    check("s4_queue_empty", exp_q.size(), 0);
    check("s4_hold_data", {24'd0, out_data}, 32'hA4);
    check("s4_overflow_sticky", {31'd0, overflow}, 1);

    // Scenario 5: reset after 12 bits, then a clean frame
    e0 = err_cnt; d0 = done_cnt;
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("s5_rst_data", {24'd0, out_data}, 0);
    check("s5_rst_bits", {27'd0, out_valid, frame_done, frame_err, overflow, busy}, 0);
    rst_n = 1'b1;
    idle_cycles(1);
    check("s5_no_err", {31'd0, frame_err}, 0);
    exp_q.push_back(8'hA7);
    send_byte(8'h01);
    send_byte(8'hA7);
    check("s5_done", {31'd0, frame_done}, 1);
    check("s5_valid", {31'd0, out_valid}, 1);
    check("s5_data", {24'd0, out_data}, 32'hA7);
    idle_cycles(4);
    check("s5_err_count", err_cnt - e0, 0);
    check("s5_done_count", done_cnt - d0, 1);
    check("s5_queue_empty", exp_q.size(), 0);
    check("s5_overflow_clear", {31'd0, overflow}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_frame_ctrl.md
SPI_FRAME_CTRL -- requirements
Module: spi_frame_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter FIFO_DEPTH SHALL default to 4, set the number of output buffer entries, and be a power of two, at least 2.
REQ-003 Port clk SHALL be an input, 1 bit wide, and be the system clock; all logic SHALL be updated on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit wide, and act as the synchronous active-low reset.
REQ-005 Port cs_n SHALL be an input, 1 bit wide, and be the frame select; the frame is active while cs_n is 0.
REQ-006 Port bit SHALL be an input, 1 bit wide, and carry serial data, MSB first.
REQ-007 Port out_data SHALL be an output, 8 bits wide, and present the payload byte at the FIFO head.
REQ-008 Port out_valid SHALL be an output, 1 bit wide, and be high when the FIFO is not empty.
REQ-009 Port out_ready SHALL be an input, 1 bit wide, and signal that the consumer accepts out_data.
REQ-010 Port frame_done SHALL be an output, 1 bit wide, and pulse for 1 cycle when a frame completes.
REQ-011 Port frame_err SHALL be an output, 1 bit wide, and pulse for 1 cycle when a frame is aborted.
REQ-012 Port overflow SHALL be an output, 1 bit wide, and be a sticky flag set when a payload byte is dropped.
REQ-013 Port busy SHALL be an output, 1 bit wide, and be high whenever the state is not IDLE.

Function
REQ-014 Bit capture SHALL occur on every clk edge where cs_n is 0 and the state is not DONE.
- Capture shifts bit into an 8-bit shift register, MSB first.
- Capture increments a 3-bit bit counter.
REQ-015 A byte SHALL be complete on the edge that captures the 8th bit; the counter then wraps to 0.
REQ-016 On any edge where cs_n is 1, the shift register and bit counter SHALL clear; partial bits are discarded.
REQ-017 The FSM SHALL have the states IDLE, LEN, DATA and DONE.
REQ-018 The FSM SHALL go from IDLE to LEN on an edge where cs_n is 0; the bit captured on that edge counts.
REQ-019 In LEN, the first complete byte SHALL load an 8-bit remaining counter L.
- If L is 0, go to DONE.
- Otherwise, go to DATA.
REQ-020 In DATA, each complete byte SHALL be pushed into the FIFO and decrement L; when L reaches 0, go to DONE on the same edge.
REQ-021 frame_done SHALL be registered and be high for exactly the 1 cycle after the edge that enters DONE.
REQ-022 In DONE, bits SHALL be ignored and the FSM SHALL go to IDLE on an edge where cs_n is 1.
REQ-023 cs_n at 1 in LEN or DATA SHALL abort the frame.
- frame_err goes high for the next cycle.
- The FSM goes to IDLE.
- Bytes already in the FIFO are kept.
REQ-024 cs_n at 1 in IDLE SHALL have no effect other than the clear in REQ-016.
REQ-025 A pushed byte SHALL be visible on out_data, with out_valid high, in the cycle after the push edge (latency 1).
REQ-026 A pop SHALL occur on an edge where out_valid and out_ready are both 1; FIFO order SHALL be first in, first out.
REQ-027 Push and pop on the same edge SHALL both succeed, including when the FIFO is full.
REQ-028 A push to a full FIFO without a pop SHALL drop the byte.
- overflow is set.
- L still decrements and the frame continues.
REQ-029 overflow SHALL be cleared only by reset.
REQ-030 out_data SHALL hold its last value while out_valid is 0.

Reset
REQ-031 An edge with rst_n at 0 SHALL set:
- state to IDLE;
- shift register, bit counter and L to 0;
- the FIFO to empty, with out_data at 0 and out_valid at 0;
- frame_done, frame_err, overflow and busy to 0.
REQ-032 Reset SHALL dominate all other inputs, including in the middle of a frame; frame_err SHALL NOT pulse on reset.

Verification
REQ-033 Scenario 1: cs_n is 0, bits are 0x02, 0xCA, 0x3F, out_ready is 1.
- Expect out_valid high with 0xCA, 1 cycle after bit 16.
- Expect out_valid high with 0x3F, 1 cycle after bit 24.
- Expect frame_done for 1 cycle after bit 24.
REQ-034 Scenario 2: the length byte is 0x00.
- Expect frame_done 1 cycle after bit 8.
- Expect out_valid never asserted.
- Extra bits before cs_n returns to 1 are ignored.
REQ-035 Scenario 3: bits are 0x03, 0x11, then 4 more bits, then cs_n goes to 1.
- Expect frame_err for 1 cycle.
- Expect busy at 0.
- Expect 0x11 still delivered and no frame_done.
REQ-036 Scenario 4: out_ready is 0, the length byte is 0x05, and 5 bytes 0xA1..0xA5 are sent.
- Expect overflow at 1 after the 5th byte, with frame_done still pulsing.
- Then set out_ready to 1: expect exactly 0xA1, 0xA2, 0xA3, 0xA4, in that order.
REQ-037 Scenario 5: rst_n goes to 0 for 1 cycle after 12 bits of a frame.
- Expect all outputs at 0.
- A following frame of 0x01, 0xA7 delivers 0xA7 with frame_done.
REQ-038 Scenario 6: with the FIFO full, do a simultaneous push and pop.
- Expect the occupancy unchanged and overflow at 0.
